// File: rtl/cus19_pc_ras.sv
// Custom19 IF-stage next-PC unit with a parametrised circular return-address stack.
// Optional interrupt entry (push pc_in, vector to irq_vec_in) under `define CUS19_RAS_IRQ_EN.
module cus19_pc_ras #(
    parameter int                    PC_WIDTH     = 11,
    parameter int                    STACK_DEPTH  = 8,
    parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = '0
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [PC_WIDTH-1:0]           pc_in,
    input  logic                          stall_in,
    input  logic                          flush_in,
    input  logic [PC_WIDTH-1:0]           flush_addr_in,
    input  logic                          branch_in,
    input  logic [1:0]                    pc_src_in,
    input  logic [PC_WIDTH-1:0]           imm_add_in,
    input  logic                          clr_err_in,
`ifdef CUS19_RAS_IRQ_EN
    input  logic                          irq_in,
    input  logic [PC_WIDTH-1:0]           irq_vec_in,
    output logic                          irq_ack_out,
`endif
    output logic [PC_WIDTH-1:0]           pc_mux_out,
    output logic [$clog2(STACK_DEPTH):0]  ras_depth_out,
    output logic                          ras_full_out,
    output logic                          ras_empty_out,
    output logic                          ras_ovf_out,
    output logic                          ras_unf_out
);

    localparam int PTR_W   = $clog2(STACK_DEPTH);
    localparam int DEPTH_W = PTR_W + 1;

    typedef enum logic [1:0] {
        SRC_SEQ  = 2'b00,
        SRC_JUMP = 2'b01,
        SRC_CALL = 2'b10,
        SRC_RET  = 2'b11
    } pc_src_e;

    logic [PC_WIDTH-1:0] stack_mem [STACK_DEPTH];

    logic [PC_WIDTH-1:0] pc_q,    pc_nxt;
    logic [PTR_W-1:0]    ptr_q,   ptr_nxt;
    logic [DEPTH_W-1:0]  depth_q, depth_nxt;
    logic                ovf_q,   ovf_nxt;
    logic                unf_q,   unf_nxt;

    logic                full, empty;
    logic                push_en, pop_en;
    logic                ovf_set, unf_set;
    logic [PC_WIDTH-1:0] push_data;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PTR_W-1:0]    top_idx;

`ifdef CUS19_RAS_IRQ_EN
    logic                ack_q, ack_nxt;
`endif

    assign pc_inc  = pc_in + 1'b1;
    assign top_idx = ptr_q - 1'b1;
    assign full    = (depth_q == DEPTH_W'(STACK_DEPTH));
    assign empty   = (depth_q == '0);

    always_comb begin
        pc_nxt    = pc_q;
        ptr_nxt   = ptr_q;
        depth_nxt = depth_q;
        push_en   = 1'b0;
        pop_en    = 1'b0;
        push_data = pc_inc;
        unf_set   = 1'b0;
        ovf_set   = 1'b0;
`ifdef CUS19_RAS_IRQ_EN
        ack_nxt   = 1'b0;
`endif

        if (stall_in) begin
            pc_nxt = pc_q;
        end else if (flush_in) begin
            pc_nxt = flush_addr_in;
`ifdef CUS19_RAS_IRQ_EN
        end else if (irq_in) begin
            // Interrupted instruction has not executed, so resume at pc_in itself.
            push_en   = 1'b1;
            push_data = pc_in;
            pc_nxt    = irq_vec_in;
            ack_nxt   = 1'b1;
`endif
        end else if (branch_in) begin
            pc_nxt = imm_add_in;
        end else begin
            unique case (pc_src_e'(pc_src_in))
                SRC_SEQ:  pc_nxt = pc_inc;
                SRC_JUMP: pc_nxt = imm_add_in;
                SRC_CALL: begin
                    push_en = 1'b1;
                    pc_nxt  = imm_add_in;
                end
                SRC_RET: begin
                    if (empty) begin
                        pc_nxt  = pc_inc;
                        unf_set = 1'b1;
                    end else begin
                        pop_en = 1'b1;
                        pc_nxt = stack_mem[top_idx];
                    end
                end
                default: pc_nxt = pc_inc;
            endcase
        end

        // A push into a full stack lands on the oldest slot, which the pointer already addresses.
        if (push_en) begin
            ptr_nxt = ptr_q + 1'b1;
            if (full) ovf_set   = 1'b1;
            else      depth_nxt = depth_q + 1'b1;
        end
        if (pop_en) begin
            ptr_nxt   = top_idx;
            depth_nxt = depth_q - 1'b1;
        end

        ovf_nxt = ovf_set | (ovf_q & ~clr_err_in);
        unf_nxt = unf_set | (unf_q & ~clr_err_in);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            pc_q    <= RESET_VECTOR;
            ptr_q   <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_nxt;
            ptr_q   <= ptr_nxt;
            depth_q <= depth_nxt;
            ovf_q   <= ovf_nxt;
            unf_q   <= unf_nxt;
        end
    end

    // Stack contents are deliberately not reset.
    always_ff @(posedge clk_in) begin
        if (rst_in && push_en)
            stack_mem[ptr_q] <= push_data;
    end

`ifdef CUS19_RAS_IRQ_EN
    always_ff @(posedge clk_in) begin
        if (!rst_in) ack_q <= 1'b0;
        else         ack_q <= ack_nxt;
    end
    assign irq_ack_out = ack_q;
`endif

    assign pc_mux_out    = pc_q;
    assign ras_depth_out = depth_q;
    assign ras_full_out  = full;
    assign ras_empty_out = empty;
    assign ras_ovf_out   = ovf_q;
    assign ras_unf_out   = unf_q;

endmodule

// File: tb/tb_cus19_pc_ras.sv
// Self-checking bench for cus19_pc_ras: directed scenarios plus a randomised call/return scoreboard.
module tb_cus19_pc_ras;

    localparam int PW = 11;
    localparam int SD = 8;

    logic          clk_in = 1'b0;
    logic          rst_in, stall_in, flush_in, branch_in, clr_err_in;
    logic [PW-1:0] pc_in, flush_addr_in, imm_add_in;
    logic [1:0]    pc_src_in;
    logic [PW-1:0] pc_mux_out;
    logic [3:0]    ras_depth_out;
    logic          ras_full_out, ras_empty_out, ras_ovf_out, ras_unf_out;

    typedef struct {
        logic [PW-1:0] pc;
        logic [3:0]    depth;
        logic          ovf;
        logic          unf;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          e;
    logic [PW-1:0] model_stack[$];
    int            checks = 0;
    int            passes = 0;

    always #5 clk_in = ~clk_in;

    cus19_pc_ras dut (
        .clk_in(clk_in), .rst_in(rst_in), .pc_in(pc_in), .stall_in(stall_in),
        .flush_in(flush_in), .flush_addr_in(flush_addr_in), .branch_in(branch_in),
        .pc_src_in(pc_src_in), .imm_add_in(imm_add_in), .clr_err_in(clr_err_in),
        .pc_mux_out(pc_mux_out), .ras_depth_out(ras_depth_out),
        .ras_full_out(ras_full_out), .ras_empty_out(ras_empty_out),
        .ras_ovf_out(ras_ovf_out), .ras_unf_out(ras_unf_out)
    );

    task automatic set_idle();
        rst_in = 1'b1; stall_in = 1'b0; flush_in = 1'b0; branch_in = 1'b0;
        clr_err_in = 1'b0; flush_addr_in = '0; pc_src_in = 2'b00;
        pc_in = '0; imm_add_in = '0;
    endtask

    // Drives one request, clocks it in and samples 1 ns after the edge.
    task automatic drive(input logic [1:0] src, input logic [PW-1:0] pc, input logic [PW-1:0] imm);
        pc_src_in = src; pc_in = pc; imm_add_in = imm;
        @(posedge clk_in); #1;
        set_idle();
    endtask

    task automatic push_exp(input logic [PW-1:0] pc, input int depth, input logic ovf, input logic unf);
        exp_t x;
        x.pc = pc; x.depth = 4'(depth); x.ovf = ovf; x.unf = unf;
        exp_q.push_back(x);
    endtask

    task automatic test_reset();
        set_idle();
        rst_in = 1'b0;
        drive(2'b10, 11'h123, 11'h456);
        checks++;
        if (pc_mux_out !== 11'h000 || ras_depth_out !== 4'd0 || ras_empty_out !== 1'b1 ||
            ras_full_out !== 1'b0 || ras_ovf_out !== 1'b0 || ras_unf_out !== 1'b0)
            $display("FAIL reset: got pc=%h depth=%0d empty=%b full=%b ovf=%b unf=%b, want pc=000 depth=0 empty=1 full=0 ovf=0 unf=0",
                     pc_mux_out, ras_depth_out, ras_empty_out, ras_full_out, ras_ovf_out, ras_unf_out);
        else passes++;
    endtask

    task automatic test_seq_jump();
        logic [PW-1:0] pcs [3] = '{11'h7FF, 11'h123, 11'h000};
        foreach (pcs[i]) begin
            push_exp(pcs[i] + 1'b1, 0, 1'b0, 1'b0);
            drive(2'b00, pcs[i], 11'h5A5);
            e = exp_q.pop_front();
            checks++;
            if (pc_mux_out !== e.pc || ras_depth_out !== e.depth)
                $display("FAIL seq[%0d]: got pc=%h depth=%0d, want pc=%h depth=%0d", i, pc_mux_out, ras_depth_out, e.pc, e.depth);
            else passes++;
        end
        push_exp(11'h2AA, 0, 1'b0, 1'b0);
        drive(2'b01, 11'h010, 11'h2AA);
        e = exp_q.pop_front();
        checks++;
        if (pc_mux_out !== e.pc || ras_depth_out !== e.depth)
            $display("FAIL jump: got pc=%h depth=%0d, want pc=%h depth=%0d", pc_mux_out, ras_depth_out, e.pc, e.depth);
        else passes++;
    endtask

    task automatic test_nested();
        logic [PW-1:0] cpc [3] = '{11'h010, 11'h020, 11'h030};
        logic [PW-1:0] ret [3] = '{11'h031, 11'h021, 11'h011};
        for (int i = 0; i < 3; i++) begin
            push_exp(11'((i + 1) * 'h100), i + 1, 1'b0, 1'b0);
            drive(2'b10, cpc[i], 11'((i + 1) * 'h100));
            e = exp_q.pop_front();
            checks++;
            if (pc_mux_out !== e.pc || ras_depth_out !== e.depth)
                $display("FAIL nested_call[%0d]: got pc=%h depth=%0d, want pc=%h depth=%0d", i, pc_mux_out, ras_depth_out, e.pc, e.depth);
            else passes++;
        end
        for (int i = 0; i < 3; i++) begin
            push_exp(ret[i], 2 - i, 1'b0, 1'b0);
            drive(2'b11, 11'h3F0, 11'h000);
            e = exp_q.pop_front();
            checks++;
            if (pc_mux_out !== e.pc || ras_depth_out !== e.depth)
                $display("FAIL nested_ret[%0d]: got pc=%h depth=%0d, want pc=%h depth=%0d", i, pc_mux_out, ras_depth_out, e.pc, e.depth);
            else passes++;
        end
        checks++;
        if (ras_empty_out !== 1'b1) $display("FAIL nested_empty: got %b want 1", ras_empty_out);
        else passes++;
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 9; i++) begin
            push_exp(11'(12'h400 + i), (i > SD) ? SD : i, i > SD, 1'b0);
            drive(2'b10, 11'(i), 11'(12'h400 + i));
            e = exp_q.pop_front();
            checks++;
            if (pc_mux_out !== e.pc || ras_depth_out !== e.depth || ras_ovf_out !== e.ovf ||
                ras_full_out !== (e.depth == SD))
                $display("FAIL ovf_call[%0d]: got pc=%h depth=%0d ovf=%b full=%b, want pc=%h depth=%0d ovf=%b",
                         i, pc_mux_out, ras_depth_out, ras_ovf_out, ras_full_out, e.pc, e.depth, e.ovf);
            else passes++;
        end
        // Oldest (0x002) was overwritten; returns come back 0x00A down to 0x003.
        for (int i = 0; i < SD; i++) begin
            push_exp(11'(10 - i), SD - 1 - i, 1'b1, 1'b0);
            drive(2'b11, 11'h050, 11'h000);
            e = exp_q.pop_front();
            checks++;
            if (pc_mux_out !== e.pc || ras_depth_out !== e.depth || ras_ovf_out !== e.ovf)
                $display("FAIL ovf_ret[%0d]: got pc=%h depth=%0d ovf=%b, want pc=%h depth=%0d ovf=%b",
                         i, pc_mux_out, ras_depth_out, ras_ovf_out, e.pc, e.depth, e.ovf);
            else passes++;
        end
        push_exp(11'h051, 0, 1'b1, 1'b1);
        drive(2'b11, 11'h050, 11'h000);
        e = exp_q.pop_front();
        checks++;
        if (pc_mux_out !== e.pc || ras_depth_out !== e.depth || ras_unf_out !== e.unf || ras_ovf_out !== e.ovf)
            $display("FAIL underflow: got pc=%h depth=%0d ovf=%b unf=%b, want pc=%h depth=0 ovf=1 unf=1",
                     pc_mux_out, ras_depth_out, ras_ovf_out, ras_unf_out, e.pc);
        else passes++;
        // Set wins over clear in the same cycle; ovf has no set so it clears.
        clr_err_in = 1'b1;
        drive(2'b11, 11'h060, 11'h000);
        checks++;
        if (ras_unf_out !== 1'b1 || ras_ovf_out !== 1'b0 || pc_mux_out !== 11'h061)
            $display("FAIL set_over_clear: got unf=%b ovf=%b pc=%h, want unf=1 ovf=0 pc=061", ras_unf_out, ras_ovf_out, pc_mux_out);
        else passes++;
        clr_err_in = 1'b1;
        drive(2'b00, 11'h070, 11'h000);
        checks++;
        if (ras_unf_out !== 1'b0 || ras_ovf_out !== 1'b0)
            $display("FAIL clr_err: got unf=%b ovf=%b, want 0 0", ras_unf_out, ras_ovf_out);
        else passes++;
    endtask

    task automatic test_priority();
        drive(2'b10, 11'h060, 11'h600);
        flush_in = 1'b1; flush_addr_in = 11'h155; branch_in = 1'b1;
        drive(2'b10, 11'h0F0, 11'h3FF);
        checks++;
        if (pc_mux_out !== 11'h155 || ras_depth_out !== 4'd1 || ras_ovf_out !== 1'b0)
            $display("FAIL flush_prio: got pc=%h depth=%0d, want pc=155 depth=1", pc_mux_out, ras_depth_out);
        else passes++;
        branch_in = 1'b1;
        drive(2'b11, 11'h0F0, 11'h0AB);
        checks++;
        if (pc_mux_out !== 11'h0AB || ras_depth_out !== 4'd1)
            $display("FAIL branch_prio: got pc=%h depth=%0d, want pc=0ab depth=1", pc_mux_out, ras_depth_out);
        else passes++;
        drive(2'b11, 11'h0F0, 11'h000);
        checks++;
        if (pc_mux_out !== 11'h061 || ras_depth_out !== 4'd0)
            $display("FAIL after_flush_ret: got pc=%h depth=%0d, want pc=061 depth=0", pc_mux_out, ras_depth_out);
        else passes++;
    endtask

    task automatic test_stall();
        drive(2'b11, 11'h002, 11'h000);
        drive(2'b10, 11'h070, 11'h700);
        drive(2'b10, 11'h080, 11'h701);
        for (int i = 0; i < 2; i++) begin
            stall_in = 1'b1; clr_err_in = 1'b1;
            drive(2'b11, 11'h003, 11'h000);
            checks++;
            if (pc_mux_out !== 11'h701 || ras_depth_out !== 4'd2 || ras_unf_out !== 1'b0)
                $display("FAIL stall_hold[%0d]: got pc=%h depth=%0d unf=%b, want pc=701 depth=2 unf=0",
                         i, pc_mux_out, ras_depth_out, ras_unf_out);
            else passes++;
        end
        drive(2'b11, 11'h003, 11'h000);
        checks++;
        if (pc_mux_out !== 11'h081 || ras_depth_out !== 4'd1)
            $display("FAIL stall_release: got pc=%h depth=%0d, want pc=081 depth=1", pc_mux_out, ras_depth_out);
        else passes++;
        drive(2'b11, 11'h003, 11'h000);
        checks++;
        if (pc_mux_out !== 11'h071 || ras_depth_out !== 4'd0)
            $display("FAIL stall_release2: got pc=%h depth=%0d, want pc=071 depth=0", pc_mux_out, ras_depth_out);
        else passes++;
    endtask

    // Behavioural stack model: newest at the back, oldest dropped when full.
    task automatic test_back_to_back();
        logic [PW-1:0] pc, imm, exp_pc;
        logic          ovf = 1'b0, unf = 1'b0;
        int            op;
        model_stack.delete();
        for (int n = 0; n < 200; n++) begin
            op  = int'($urandom_range(0, 9));
            pc  = PW'($urandom);
            imm = PW'($urandom);
            if (op <= 3) begin
                exp_pc = imm;
                if (model_stack.size() == SD) begin
                    void'(model_stack.pop_front());
                    ovf = 1'b1;
                end
                model_stack.push_back(pc + 1'b1);
                push_exp(exp_pc, model_stack.size(), ovf, unf);
                drive(2'b10, pc, imm);
            end else if (op <= 7) begin
                if (model_stack.size() == 0) begin
                    exp_pc = pc + 1'b1;
                    unf = 1'b1;
                end else exp_pc = model_stack.pop_back();
                push_exp(exp_pc, model_stack.size(), ovf, unf);
                drive(2'b11, pc, imm);
            end else if (op == 8) begin
                push_exp(imm, model_stack.size(), ovf, unf);
                branch_in = 1'b1;
                drive(2'(n), pc, imm);
            end else begin
                push_exp(pc + 1'b1, model_stack.size(), ovf, unf);
                drive(2'b00, pc, imm);
            end
            e = exp_q.pop_front();
            checks++;
            if (pc_mux_out !== e.pc || ras_depth_out !== e.depth || ras_ovf_out !== e.ovf || ras_unf_out !== e.unf)
                $display("FAIL b2b[%0d]: got pc=%h depth=%0d ovf=%b unf=%b, want pc=%h depth=%0d ovf=%b unf=%b",
                         n, pc_mux_out, ras_depth_out, ras_ovf_out, ras_unf_out, e.pc, e.depth, e.ovf, e.unf);
            else passes++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        set_idle();
        @(posedge clk_in); #1;
        test_reset();
        test_seq_jump();
        test_nested();
        test_overflow();
        test_priority();
        test_stall();
        set_idle();
        rst_in = 1'b0;
        drive(2'b00, 11'h000, 11'h000);
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/cus19_pc_ras.md
Name: cus19_pc_ras

Overview:
Next-generation PC update unit for the Custom19 IF stage. It computes the next PC from sequential, jump, branch, call and return requests. A parametrised circular return-address stack (RAS) replaces the fixed 8-entry stack. Adds stall, pipeline flush/redirect, occupancy reporting and sticky overflow/underflow error flags. Feeds the instruction-memory address and the IF/ID register.

Parameters:
PC_WIDTH, 11, width of every PC/address bus
STACK_DEPTH, 8, RAS entries; power of two, >= 2
RESET_VECTOR, 0, PC value loaded on reset (PC_WIDTH bits)

Ports:
clk_in  input  1  clock, all state updates on rising edge
rst_in  input  1  synchronous reset, active-low
pc_in  input  PC_WIDTH  PC of instruction currently fetched
stall_in  input  1  hold PC and RAS unchanged
flush_in  input  1  pipeline redirect request (exception/mispredict)
flush_addr_in  input  PC_WIDTH  redirect target
branch_in  input  1  branch taken, from branch unit
pc_src_in  input  2  00 seq, 01 jump, 10 call, 11 return
imm_add_in  input  PC_WIDTH  jump/branch/call target
clr_err_in  input  1  clears sticky error flags
pc_mux_out  output  PC_WIDTH  next PC (registered)
ras_depth_out  output  $clog2(STACK_DEPTH)+1  valid entries, 0..STACK_DEPTH
ras_full_out  output  1  depth == STACK_DEPTH (combinational from depth)
ras_empty_out  output  1  depth == 0
ras_ovf_out  output  1  sticky: call issued while full
ras_unf_out  output  1  sticky: return issued while empty

Behaviour:
- Synchronous reset when rst_in==0 at a clock edge: pc_mux_out=RESET_VECTOR, depth=0, top pointer=0, ovf=unf=0. RAS contents are not reset. Reset overrides every other input, including mid-call/return.
- Registered outputs; all updates take effect one cycle after the request.
- Priority, highest first: reset > stall > flush > branch > pc_src.
- stall_in=1: pc_mux_out, pointer, depth and contents hold; flag clearing still honoured.
- flush_in=1: pc_mux_out=flush_addr_in; RAS untouched.
- branch_in=1: pc_mux_out=imm_add_in; pc_src ignored.
- pc_src 00: pc_mux_out=pc_in+1, modulo 2^PC_WIDTH (0x7FF wraps to 0x000 at default).
- pc_src 01: pc_mux_out=imm_add_in.
- pc_src 10 (call):
  - write pc_in+1 (mod 2^PC_WIDTH) at the top pointer; pointer +1 modulo STACK_DEPTH.
  - depth +1, saturating at STACK_DEPTH; pc_mux_out=imm_add_in.
  - If already full: oldest entry is overwritten (circular), depth stays STACK_DEPTH, ras_ovf_out set.
- pc_src 11 (return):
  - if depth>0: pc_mux_out=entry at (pointer-1) mod STACK_DEPTH; pointer -1; depth -1.
  - if depth==0: pc_mux_out=pc_in+1, pointer and depth unchanged, ras_unf_out set.
- Sticky flags: set conditions apply only when the call/return is actually executed (not stalled/flushed/branched). clr_err_in clears both; a set in the same cycle wins over clear.
- No combinational path from inputs to pc_mux_out.

Optional Feature:
Macro CUS19_RAS_IRQ_EN.
- Defined: adds ports irq_in (1) and irq_vec_in (PC_WIDTH), plus output irq_ack_out (1, registered, reset 0).
  - irq_in sits below flush and above branch in priority.
  - When taken: push pc_in (not pc_in+1) with the same full/ovf rules as a call, pc_mux_out=irq_vec_in, irq_ack_out pulses high for exactly one cycle.
  - Return uses the normal pc_src 11 path.
- Undefined: these ports and this logic are absent; behaviour is exactly as above.

Test Plan:
- Reset: drive rst_in=0 with pc_src=10 for one edge -> pc_mux_out=0, depth 0, empty=1, ovf=unf=0.
- Sequential wrap: pc_in=0x7FF, pc_src=00 -> pc_mux_out=0x000.
- Nested calls/returns:
  - calls at pc_in=0x010, 0x020, 0x030 (targets 0x100/0x200/0x300) -> depth 3.
  - three returns -> pc_mux_out 0x031, 0x021, 0x011, depth 0.
- Overflow: 9 calls at pc_in=0x001..0x009 (depth 8) -> ovf=1, depth 8.
  - 8 returns yield 0x00A down to 0x003.
  - 9th return yields pc_in+1 and sets unf=1.
  - clr_err_in then clears both flags.
- Priority: flush_in=1 (addr 0x155) with branch_in=1 and pc_src=10 -> pc_mux_out=0x155, depth unchanged, no push.
- Stall: stall_in=1 with pc_src=11, depth 2 -> PC and depth hold.
  - Release stall -> return executes one cycle later.
